// File: rtl/pipeline_control_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, load-type
// "none" code, register x0 address and flush counter width.
package pipeline_control_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_DC_WAIT = 2'd2
   } hazard_state_t;

   localparam logic [2:0] LOAD_NONE = 3'b000;
   localparam logic [4:0] REG_X0    = 5'd0;
   localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/load_use_detector.sv
// Pure comparator: flags an ID-stage operand that depends on a load still in EX.
// Writes to x0 never create a dependency.
module load_use_detector
   import pipeline_control_pkg::*;
(
   input  logic [4:0] rs1_address,
   input  logic [4:0] rs2_address,
   input  logic       rs1_used,
   input  logic       rs2_used,
   input  logic [4:0] rd_address,
   input  logic [2:0] load_type,
   output logic       hit
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = rs1_used && (rs1_address == rd_address);
   assign rs2_match = rs2_used && (rs2_address == rd_address);
   assign hit = (load_type != LOAD_NONE) && (rd_address != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional perf counters are
// built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller
   import pipeline_control_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES     = 2,
   parameter int unsigned PERF_COUNT_WIDTH = 32
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] RS1_ADDRESS_ID,
   input  logic [4:0] RS2_ADDRESS_ID,
   input  logic       RS1_USED_ID,
   input  logic       RS2_USED_ID,
   input  logic [4:0] RD_ADDRESS_EX,
   input  logic [2:0] DATA_CACHE_LOAD_EX,
   input  logic       BRANCH_TAKEN,
   input  logic       DATA_CACHE_ACCESS_MEM,
   input  logic       DATA_CACHE_READY,
   input  logic       INSTRUCTION_CACHE_READY,
   output logic       STALL_PROGRAM_COUNTER,
   output logic       STALL_INSTRUCTION_FETCH,
   output logic       STALL_DECODING,
   output logic       STALL_EXECUTION_STAGE,
   output logic       STALL_DATA_MEMORY,
   output logic       CLEAR_INSTRUCTION_FETCH,
   output logic       CLEAR_DECODING,
   output logic [1:0] HAZARD_STATE
`ifdef HAZARD_PERF_COUNTERS_EN
   ,
   output logic [PERF_COUNT_WIDTH-1:0] STALL_CYCLE_COUNT,
   output logic [PERF_COUNT_WIDTH-1:0] FLUSH_CYCLE_COUNT
`endif
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   hazard_state_t          state;
   hazard_state_t          saved_state;
   hazard_state_t          eff_state;
   logic [FLUSH_CNT_W-1:0] flush_cnt;
   logic                   dc_miss;
   logic                   load_use;
   logic                   flush_clear;

   load_use_detector u_load_use (
      .rs1_address (RS1_ADDRESS_ID),
      .rs2_address (RS2_ADDRESS_ID),
      .rs1_used    (RS1_USED_ID),
      .rs2_used    (RS2_USED_ID),
      .rd_address  (RD_ADDRESS_EX),
      .load_type   (DATA_CACHE_LOAD_EX),
      .hit         (load_use)
   );

   assign dc_miss = DATA_CACHE_ACCESS_MEM && !DATA_CACHE_READY;
   // On the release cycle of a D-cache wait, hazards resolve against the interrupted state.
   assign eff_state = (state == ST_DC_WAIT) ? saved_state : state;
   assign HAZARD_STATE = state;

   always_comb begin
      STALL_PROGRAM_COUNTER   = 1'b0;
      STALL_INSTRUCTION_FETCH = 1'b0;
      STALL_DECODING          = 1'b0;
      STALL_EXECUTION_STAGE   = 1'b0;
      STALL_DATA_MEMORY       = 1'b0;
      CLEAR_INSTRUCTION_FETCH = 1'b0;
      CLEAR_DECODING          = 1'b0;
      flush_clear             = 1'b0;
      if (RST) begin
         CLEAR_INSTRUCTION_FETCH = 1'b1;
         CLEAR_DECODING          = 1'b1;
      end else if (dc_miss) begin
         STALL_PROGRAM_COUNTER   = 1'b1;
         STALL_INSTRUCTION_FETCH = 1'b1;
         STALL_DECODING          = 1'b1;
         STALL_EXECUTION_STAGE   = 1'b1;
         STALL_DATA_MEMORY       = 1'b1;
      end else if (BRANCH_TAKEN) begin
         CLEAR_INSTRUCTION_FETCH = 1'b1;
         CLEAR_DECODING          = 1'b1;
         flush_clear             = 1'b1;
      end else if (eff_state == ST_FLUSH) begin
         CLEAR_INSTRUCTION_FETCH = 1'b1;
         flush_clear             = 1'b1;
      end else begin
         if (load_use) begin
            STALL_PROGRAM_COUNTER   = 1'b1;
            STALL_INSTRUCTION_FETCH = 1'b1;
            CLEAR_DECODING          = 1'b1;
         end
         if (!INSTRUCTION_CACHE_READY) begin
            STALL_PROGRAM_COUNTER   = 1'b1;
            CLEAR_INSTRUCTION_FETCH = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= ST_RUN;
         saved_state <= ST_RUN;
         flush_cnt   <= '0;
      end else if (dc_miss) begin
         // Counter stays frozen; only the first miss cycle captures the state.
         if (state != ST_DC_WAIT) saved_state <= state;
         state <= ST_DC_WAIT;
      end else if (BRANCH_TAKEN) begin
         flush_cnt <= FLUSH_RELOAD;
         state     <= (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
      end else if (eff_state == ST_FLUSH) begin
         flush_cnt <= flush_cnt - 1'b1;
         state     <= (flush_cnt <= FLUSH_CNT_W'(1)) ? ST_RUN : ST_FLUSH;
      end else begin
         state <= ST_RUN;
      end
   end

`ifdef HAZARD_PERF_COUNTERS_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         STALL_CYCLE_COUNT <= '0;
         FLUSH_CYCLE_COUNT <= '0;
      end else begin
         if (STALL_PROGRAM_COUNTER && (STALL_CYCLE_COUNT != '1))
            STALL_CYCLE_COUNT <= STALL_CYCLE_COUNT + 1'b1;
         if (flush_clear && (FLUSH_CYCLE_COUNT != '1))
            FLUSH_CYCLE_COUNT <= FLUSH_CYCLE_COUNT + 1'b1;
      end
   end
`else
   // Without the counters the flush-cause flag has no consumer.
   logic unused_flush_clear;
   assign unused_flush_clear = flush_clear;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench: stimulus pushes hand-computed expected outputs into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_pipeline_hazard_controller;

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] RS1_ADDRESS_ID, RS2_ADDRESS_ID, RD_ADDRESS_EX;
   logic       RS1_USED_ID, RS2_USED_ID;
   logic [2:0] DATA_CACHE_LOAD_EX;
   logic       BRANCH_TAKEN, DATA_CACHE_ACCESS_MEM, DATA_CACHE_READY, INSTRUCTION_CACHE_READY;
   logic       STALL_PROGRAM_COUNTER, STALL_INSTRUCTION_FETCH, STALL_DECODING;
   logic       STALL_EXECUTION_STAGE, STALL_DATA_MEMORY;
   logic       CLEAR_INSTRUCTION_FETCH, CLEAR_DECODING;
   logic [1:0] HAZARD_STATE;
`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] STALL_CYCLE_COUNT, FLUSH_CYCLE_COUNT;
   int unsigned stall_model = 0;
`endif

   always #5 CLK = ~CLK;

   pipeline_hazard_controller #(.FLUSH_CYCLES(2), .PERF_COUNT_WIDTH(32)) dut (
      .CLK(CLK), .RST(RST),
      .RS1_ADDRESS_ID(RS1_ADDRESS_ID), .RS2_ADDRESS_ID(RS2_ADDRESS_ID),
      .RS1_USED_ID(RS1_USED_ID), .RS2_USED_ID(RS2_USED_ID),
      .RD_ADDRESS_EX(RD_ADDRESS_EX), .DATA_CACHE_LOAD_EX(DATA_CACHE_LOAD_EX),
      .BRANCH_TAKEN(BRANCH_TAKEN), .DATA_CACHE_ACCESS_MEM(DATA_CACHE_ACCESS_MEM),
      .DATA_CACHE_READY(DATA_CACHE_READY), .INSTRUCTION_CACHE_READY(INSTRUCTION_CACHE_READY),
      .STALL_PROGRAM_COUNTER(STALL_PROGRAM_COUNTER), .STALL_INSTRUCTION_FETCH(STALL_INSTRUCTION_FETCH),
      .STALL_DECODING(STALL_DECODING), .STALL_EXECUTION_STAGE(STALL_EXECUTION_STAGE),
      .STALL_DATA_MEMORY(STALL_DATA_MEMORY), .CLEAR_INSTRUCTION_FETCH(CLEAR_INSTRUCTION_FETCH),
      .CLEAR_DECODING(CLEAR_DECODING), .HAZARD_STATE(HAZARD_STATE)
`ifdef HAZARD_PERF_COUNTERS_EN
      , .STALL_CYCLE_COUNT(STALL_CYCLE_COUNT), .FLUSH_CYCLE_COUNT(FLUSH_CYCLE_COUNT)
`endif
   );

   // Expected vector: {spc, sif, sdec, sex, smem, cif, cdec, state[1:0]}
   logic [8:0] exp_q[$];
   string      name_q[$];
   int         pass_cnt = 0;
   int         total    = 0;

   function automatic logic [8:0] mk(input logic spc, sif, sdec, sex, smem, cif, cdec,
                                     input logic [1:0] hs);
      return {spc, sif, sdec, sex, smem, cif, cdec, hs};
   endfunction

   localparam logic [8:0] E_IDLE0  = 9'b0000000_00;
   localparam logic [8:0] E_RESET  = 9'b0000011_00;
   localparam logic [8:0] E_LU     = 9'b1100001_00;
   localparam logic [8:0] E_IMISS  = 9'b1000010_00;
   localparam logic [8:0] E_LUIM   = 9'b1100011_00;
   localparam logic [8:0] E_BR0    = 9'b0000011_00;
   localparam logic [8:0] E_BR1    = 9'b0000011_01;

   task automatic apply(input string nm, input logic r,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic [2:0] ld, input logic br,
                        input logic acc, input logic dcr, input logic icr, input logic [8:0] e);
      RST = r; RS1_ADDRESS_ID = rs1; RS1_USED_ID = u1; RS2_ADDRESS_ID = rs2; RS2_USED_ID = u2;
      RD_ADDRESS_EX = rd; DATA_CACHE_LOAD_EX = ld; BRANCH_TAKEN = br;
      DATA_CACHE_ACCESS_MEM = acc; DATA_CACHE_READY = dcr; INSTRUCTION_CACHE_READY = icr;
      exp_q.push_back(e);
      name_q.push_back(nm);
`ifdef HAZARD_PERF_COUNTERS_EN
      if (r) stall_model = 0;
      else if (e[8]) stall_model++;
`endif
      @(posedge CLK); #1;
   endtask

   task automatic idle(input string nm, input logic [8:0] e);
      apply(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, e);
   endtask

   task automatic dmiss(input string nm, input logic [8:0] e);
      apply(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, e);
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         logic [8:0] e, a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {STALL_PROGRAM_COUNTER, STALL_INSTRUCTION_FETCH, STALL_DECODING,
               STALL_EXECUTION_STAGE, STALL_DATA_MEMORY, CLEAR_INSTRUCTION_FETCH,
               CLEAR_DECODING, HAZARD_STATE};
         total++;
         if (a === e) pass_cnt++;
         else $display("FAIL %s: got %b expected %b", nm, a, e);
      end
   end

   initial begin
      RST = 1'b1; RS1_ADDRESS_ID = '0; RS2_ADDRESS_ID = '0; RS1_USED_ID = 0; RS2_USED_ID = 0;
      RD_ADDRESS_EX = '0; DATA_CACHE_LOAD_EX = '0; BRANCH_TAKEN = 0;
      DATA_CACHE_ACCESS_MEM = 0; DATA_CACHE_READY = 1; INSTRUCTION_CACHE_READY = 1;
      @(posedge CLK); #1;
      apply("reset0", 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1, E_RESET);
      apply("reset1", 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1, E_RESET);
      idle("idle", E_IDLE0);
      // load-use on rs2, then rd=x0 and unused-rs1 variants
      apply("lu_rs2", 0, 0, 0, 5'd5, 1, 5'd5, 3'b010, 0, 0, 1, 1, E_LU);
      idle("lu_gone", E_IDLE0);
      apply("lu_x0", 0, 0, 0, 5'd0, 1, 5'd0, 3'b010, 0, 0, 1, 1, E_IDLE0);
      apply("lu_rs1", 0, 5'd7, 1, 5'd3, 1, 5'd7, 3'b100, 0, 0, 1, 1, E_LU);
      apply("lu_rs1_unused", 0, 5'd7, 0, 5'd3, 1, 5'd7, 3'b100, 0, 0, 1, 1, E_IDLE0);
      apply("lu_noload", 0, 5'd7, 1, 5'd7, 1, 5'd7, 3'b000, 0, 0, 1, 1, E_IDLE0);
      apply("imiss", 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, E_IMISS);
      apply("lu_imiss", 0, 0, 0, 5'd5, 1, 5'd5, 3'b010, 0, 0, 1, 0, E_LUIM);
      // branch beats load-use and I-miss; FLUSH ignores them too
      apply("br_prio", 0, 0, 0, 5'd5, 1, 5'd5, 3'b010, 1, 0, 1, 0, E_BR0);
      apply("flush1", 0, 0, 0, 5'd5, 1, 5'd5, 3'b010, 0, 0, 1, 0, mk(0,0,0,0,0,1,0,2'd1));
      idle("flush_done", E_IDLE0);
      // D-cache miss in the middle of a flush
      apply("br2", 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 1, 1, E_BR0);
      dmiss("dmiss_f0", mk(1,1,1,1,1,0,0,2'd1));
      dmiss("dmiss_f1", mk(1,1,1,1,1,0,0,2'd2));
      dmiss("dmiss_f2", mk(1,1,1,1,1,0,0,2'd2));
      apply("dc_release_flush", 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 1, mk(0,0,0,0,0,1,0,2'd2));
      idle("after_resume", E_IDLE0);
      // branch reload while already flushing
      apply("br_a", 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 1, 1, E_BR0);
      apply("br_b", 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 1, 1, E_BR1);
      idle("reload_flush", mk(0,0,0,0,0,1,0,2'd1));
      idle("reload_done", E_IDLE0);
      // miss in RUN, release cycle sees load-use against saved RUN
      dmiss("dmiss_r0", mk(1,1,1,1,1,0,0,2'd0));
      apply("dc_release_lu", 0, 0, 0, 5'd9, 1, 5'd9, 3'b001, 0, 1, 1, 1, mk(1,1,0,0,0,0,1,2'd2));
      idle("run_again", E_IDLE0);
      // miss beats branch
      apply("dmiss_br", 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 0, 1, mk(1,1,1,1,1,0,0,2'd0));
      apply("dc_release_br", 0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 1, 1, mk(0,0,0,0,0,1,1,2'd2));
      idle("br_flush", mk(0,0,0,0,0,1,0,2'd1));
      idle("br_flush_done", E_IDLE0);
      // reset in the middle of a D-cache wait
      dmiss("dmiss_x0", mk(1,1,1,1,1,0,0,2'd0));
      dmiss("dmiss_x1", mk(1,1,1,1,1,0,0,2'd2));
      apply("rst_mid_wait", 1, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 1, E_RESET);
      idle("post_rst", E_IDLE0);
`ifdef HAZARD_PERF_COUNTERS_EN
      apply("perf_lu", 0, 0, 0, 5'd5, 1, 5'd5, 3'b010, 0, 0, 1, 1, E_LU);
      apply("perf_lu2", 0, 0, 0, 5'd5, 1, 5'd5, 3'b010, 0, 0, 1, 1, E_LU);
      dmiss("perf_miss", mk(1,1,1,1,1,0,0,2'd0));
      idle("perf_end", mk(0,0,0,0,0,0,0,2'd2));
      idle("perf_end2", E_IDLE0);
      total++;
      if (STALL_CYCLE_COUNT == stall_model) pass_cnt++;
      else $display("FAIL stall_count: got %0d expected %0d", STALL_CYCLE_COUNT, stall_model);
`endif
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
      if (exp_q.size() > 0) begin
         total++;
         $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
      end
      @(posedge CLK);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Consumes hazard sources: ID register operands, EX-stage load destination, EX branch outcome, instruction/data cache ready.
- Drives per-stage STALL_* and CLEAR_* (bubble) controls, including the execution stage's stall input.
- Small FSM handles multi-cycle branch-redirect flushes and data-cache miss waits.

Parameters:
FLUSH_CYCLES, 2, IF-kill cycles after a taken branch (legal 1..7; covers I-cache redirect latency)
PERF_COUNT_WIDTH, 32, width of optional performance counters

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
RS1_ADDRESS_ID  input  5  rs1 of instruction in ID
RS2_ADDRESS_ID  input  5  rs2 of instruction in ID
RS1_USED_ID  input  1  ID instruction reads rs1
RS2_USED_ID  input  1  ID instruction reads rs2
RD_ADDRESS_EX  input  5  rd of instruction in EX
DATA_CACHE_LOAD_EX  input  3  load type in EX; non-zero = load
BRANCH_TAKEN  input  1  EX resolved taken branch/jump
DATA_CACHE_ACCESS_MEM  input  1  MEM instruction accesses data cache
DATA_CACHE_READY  input  1  data cache can complete access this cycle
INSTRUCTION_CACHE_READY  input  1  instruction cache delivers valid word
STALL_PROGRAM_COUNTER  output  1  hold PC
STALL_INSTRUCTION_FETCH  output  1  hold IF/ID register
STALL_DECODING  output  1  hold ID/EX register
STALL_EXECUTION_STAGE  output  1  hold EX/MEM register
STALL_DATA_MEMORY  output  1  hold MEM/WB register
CLEAR_INSTRUCTION_FETCH  output  1  load bubble into IF/ID
CLEAR_DECODING  output  1  load bubble into ID/EX
HAZARD_STATE  output  2  FSM state (debug): 0 RUN, 1 FLUSH, 2 DC_WAIT

Behaviour:
- Outputs are combinational from current state and inputs (same-cycle); state and flush counter update on rising CLK.
- RST high: state=RUN, counter=0, all STALL_*=0, CLEAR_*=1, HAZARD_STATE=0. Reset mid-flush or mid-miss abandons it.
- DC_MISS = DATA_CACHE_ACCESS_MEM & ~DATA_CACHE_READY.
- Priority, highest first, in every state:
- P1 DC_MISS: all five STALL_*=1, CLEAR_*=0. Save current state (RUN/FLUSH) and counter; go to DC_WAIT; counter frozen. All other hazards ignored that cycle.
- P2 BRANCH_TAKEN: CLEAR_INSTRUCTION_FETCH=1, CLEAR_DECODING=1, no stalls. Counter loads FLUSH_CYCLES-1. Next state FLUSH if that is >0, else RUN. In FLUSH, a new BRANCH_TAKEN reloads the counter.
- P3 state FLUSH (no branch): CLEAR_INSTRUCTION_FETCH=1 only; counter decrements; on 1->0 go to RUN. Load-use and I-cache miss ignored (squashed fetch).
- P4 load-use (RUN only): DATA_CACHE_LOAD_EX!=0 & RD_ADDRESS_EX!=0 & ((RS1_USED_ID & RS1_ADDRESS_ID==RD_ADDRESS_EX) | (RS2_USED_ID & RS2_ADDRESS_ID==RD_ADDRESS_EX)) -> STALL_PROGRAM_COUNTER=1, STALL_INSTRUCTION_FETCH=1, CLEAR_DECODING=1. One cycle: load then leaves EX.
- P5 I-cache miss (RUN only): ~INSTRUCTION_CACHE_READY -> STALL_PROGRAM_COUNTER=1, CLEAR_INSTRUCTION_FETCH=1.
- P4 and P5 together: union of both output sets.
- DC_WAIT: while DC_MISS, all stalls held. Cycle DATA_CACHE_READY=1: stalls released that cycle; evaluate P2..P5 against the saved state; next state is saved state (or per P2).
- rd=x0 never produces a load-use stall.

Optional Feature:
HAZARD_PERF_COUNTERS_EN
- Defined: adds outputs STALL_CYCLE_COUNT and FLUSH_CYCLE_COUNT [PERF_COUNT_WIDTH-1:0].
- STALL_CYCLE_COUNT increments each cycle STALL_PROGRAM_COUNTER=1; FLUSH_CYCLE_COUNT increments each cycle CLEAR_INSTRUCTION_FETCH=1 due to P2/P3.
- Both saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pipeline_control_pkg: state encoding (RUN=2'd0, FLUSH=2'd1, DC_WAIT=2'd2), load-type "none"=3'b000, x0 address constant.
- One sub-module natural: load_use_detector (pure comparator producing the P4 hit), reused by forwarding logic.

Test Plan:
- Load-use: DATA_CACHE_LOAD_EX=3'b010, RD_ADDRESS_EX=5, RS2_ADDRESS_ID=5, RS2_USED_ID=1 -> one cycle STALL_PROGRAM_COUNTER=1, STALL_INSTRUCTION_FETCH=1, CLEAR_DECODING=1; same with RD_ADDRESS_EX=0 -> no stall.
- Branch, FLUSH_CYCLES=2: BRANCH_TAKEN pulse -> cycle 0 CLEAR_INSTRUCTION_FETCH=1 and CLEAR_DECODING=1; cycle 1 CLEAR_INSTRUCTION_FETCH=1, HAZARD_STATE=1; cycle 2 HAZARD_STATE=0.
- D-cache miss during FLUSH: READY low 3 cycles -> all STALL_*=1 for 3 cycles, HAZARD_STATE=2; then FLUSH resumes with 1 remaining cycle.
- Simultaneous BRANCH_TAKEN with load-use and I-cache miss -> only branch clears, no stalls.
- RST asserted mid-DC_WAIT -> outputs immediately STALL_*=0, CLEAR_*=1; after release HAZARD_STATE=0.
- With HAZARD_PERF_COUNTERS_EN: 4 load-use stalls plus 3 miss cycles -> STALL_CYCLE_COUNT=7; preload to near max -> saturates at all-ones.
